// File: rtl/add_stream_pkg.sv
// Shared sizing for the adder streaming controller and its result buffer.
package add_stream_pkg;

    localparam int WIDTH     = 32;
    localparam int LATENCY   = 2;
    localparam int RES_DEPTH = 4;
    localparam int SUM_W     = WIDTH + 1;

    // Ceiling log2; clog2(1) == 0, so callers needing a nonzero width must guard it.
    function automatic int clog2(input int value);
        int result;
        int remain;
        result = 0;
        remain = value - 1;
        while (remain > 0) begin
            result = result + 1;
            remain = remain >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head output; storage clears on reset so the head reads 0.
module sync_fifo
    import add_stream_pkg::*;
#(
    parameter int DATA_W = SUM_W,
    parameter int DEPTH  = RES_DEPTH,
    localparam int PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1,
    localparam int CNT_W = clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [CNT_W-1:0]  count_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wrPtr_q;
    logic [PTR_W-1:0]  rdPtr_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              doPush;
    logic              doPop;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rdPtr_q];

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign doPop  = pop_i && !empty_o;
    assign doPush = push_i && (!full_o || doPop);

    always_comb begin
        count_d = count_q;
        case ({doPush, doPop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                mem_q[wrPtr_q] <= data_i;
                wrPtr_q        <= nextPtr(wrPtr_q);
            end
            if (doPop) begin
                rdPtr_q <= nextPtr(rdPtr_q);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/add_stream_ctrl.sv
// Valid/ready front and back end for the fixed-latency registered adder.
// Credits cover pipe plus buffer, so a result arriving from the adder always has a slot.
module add_stream_ctrl
    import add_stream_pkg::*;
#(
    parameter int WIDTH     = add_stream_pkg::WIDTH,
    parameter int LATENCY   = add_stream_pkg::LATENCY,
    parameter int RES_DEPTH = add_stream_pkg::RES_DEPTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_a,
    input  logic [WIDTH-1:0] s_b,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH:0]   add_sum,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH:0]   m_sum,
    output logic             busy
);

    localparam int OCC_W = clog2(RES_DEPTH + 1);
    localparam int CNT_W = clog2(RES_DEPTH + 1);

    logic [LATENCY-1:0] validPipe_q;
    logic [LATENCY-1:0] validPipe_d;
    logic [OCC_W-1:0]   occ_q;
    logic [OCC_W-1:0]   occ_d;
    logic               fire;
    logic               pop;
    logic               cap;
    logic               fifoFull;
    logic               fifoEmpty;
    logic [CNT_W-1:0]   fifoCount;

    // s_ready depends only on registered occupancy and reset, never on m_ready.
    assign s_ready = reset && (occ_q < OCC_W'(RES_DEPTH));
    assign fire    = s_valid && s_ready;
    assign add_a   = fire ? s_a : '0;
    assign add_b   = fire ? s_b : '0;

    assign m_valid = reset && !fifoEmpty;
    assign pop     = m_valid && m_ready;
    assign busy    = reset && ((occ_q != '0) || (fifoCount != '0));
    assign cap     = validPipe_q[LATENCY-1];

    always_comb begin
        validPipe_d    = validPipe_q << 1;
        validPipe_d[0] = fire;
    end

    always_comb begin
        occ_d = occ_q;
        case ({fire, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            validPipe_q <= '0;
            occ_q       <= '0;
        end else begin
            validPipe_q <= validPipe_d;
            occ_q       <= occ_d;
        end
    end

    sync_fifo #(
        .DATA_W (WIDTH + 1),
        .DEPTH  (RES_DEPTH)
    ) resultFifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (cap && (!fifoFull || pop)),
        .data_i  (add_sum),
        .pop_i   (pop),
        .data_o  (m_sum),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .count_o (fifoCount)
    );

endmodule

// File: tb/tb_add_stream_ctrl.sv
// Directed and random checks of add_stream_ctrl against a two-stage adder model and a sum scoreboard.
module tb_add_stream_ctrl;
    import add_stream_pkg::*;

    logic             clock;
    logic             reset;
    logic             s_valid;
    logic             s_ready;
    logic [31:0]      s_a;
    logic [31:0]      s_b;
    logic [31:0]      add_a;
    logic [31:0]      add_b;
    logic [32:0]      add_sum;
    logic             m_valid;
    logic             m_ready;
    logic [32:0]      m_sum;
    logic             busy;

    logic [32:0]      addStage1;
    logic [32:0]      addStage2;
    logic [32:0]      sbQ[$];
    int               testCount;
    int               failCount;
    int               acceptCount;
    int               popCount;

    add_stream_ctrl #(
        .WIDTH     (32),
        .LATENCY   (2),
        .RES_DEPTH (4)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_a     (s_a),
        .s_b     (s_b),
        .add_a   (add_a),
        .add_b   (add_b),
        .add_sum (add_sum),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_sum   (m_sum),
        .busy    (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Adder model: two register stages, deliberately not cleared by reset so stale sums can surface.
    always @(posedge clock) begin
        addStage1 <= {1'b0, add_a} + {1'b0, add_b};
        addStage2 <= addStage1;
    end
    assign add_sum = addStage2;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testCount++;
        assert (obs === exp)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive just after the rising edge, return at the falling edge for sampling.
    task automatic applyStimulus(input logic rst, input logic v, input logic [31:0] a,
                                 input logic [31:0] b, input logic mr);
        @(posedge clock);
        #1;
        reset   = rst;
        s_valid = v;
        s_a     = a;
        s_b     = b;
        m_ready = mr;
        @(negedge clock);
    endtask

    // Scoreboard: queue depth equals results owed, which is exactly the credit count.
    always @(negedge clock) begin
        if (reset === 1'b1) begin
            checkOutput("sReadyCredit", {63'd0, s_ready}, {63'd0, (sbQ.size() < 4)});
            if (m_valid === 1'b1) begin
                checkOutput("noSpuriousResult", {63'd0, (sbQ.size() != 0)}, 64'd1);
                if (m_ready === 1'b1 && sbQ.size() != 0) begin
                    checkOutput("sumInOrder", {31'd0, m_sum}, {31'd0, sbQ.pop_front()});
                    popCount++;
                end
            end
            if (s_valid === 1'b1 && s_ready === 1'b1) begin
                sbQ.push_back({1'b0, s_a} + {1'b0, s_b});
                acceptCount++;
            end
        end
    end

    initial begin
        int popBase;
        int target;
        int cycles;
        testCount   = 0;
        failCount   = 0;
        acceptCount = 0;
        popCount    = 0;
        reset       = 1'b0;
        s_valid     = 1'b0;
        s_a         = '0;
        s_b         = '0;
        m_ready     = 1'b0;

        // Reset with s_valid high: everything must stay quiet and operands gated.
        applyStimulus(1'b0, 1'b1, 32'hDEAD, 32'hBEEF, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'hDEAD, 32'hBEEF, 1'b1);
        checkOutput("rstReady", {63'd0, s_ready}, 64'd0);
        checkOutput("rstMValid", {63'd0, m_valid}, 64'd0);
        checkOutput("rstBusy", {63'd0, busy}, 64'd0);
        checkOutput("rstAddA", {32'd0, add_a}, 64'd0);
        checkOutput("rstAddB", {32'd0, add_b}, 64'd0);
        applyStimulus(1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
        checkOutput("readyAfterRelease", {63'd0, s_ready}, 64'd1);

        // Single carry-out pair: latency 3 to m_valid, busy clears after the pop.
        applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFF, 32'd1, 1'b1);
        checkOutput("fireAddA", {32'd0, add_a}, 64'hFFFF_FFFF);
        applyStimulus(1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
        checkOutput("lat1MValid", {63'd0, m_valid}, 64'd0);
        applyStimulus(1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
        checkOutput("lat2MValid", {63'd0, m_valid}, 64'd0);
        applyStimulus(1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
        checkOutput("lat3MValid", {63'd0, m_valid}, 64'd1);
        checkOutput("carrySum", {31'd0, m_sum}, 64'h1_0000_0000);
        checkOutput("busyHeld", {63'd0, busy}, 64'd1);
        applyStimulus(1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
        checkOutput("busyFalls", {63'd0, busy}, 64'd0);

        // Back-to-back stream with the consumer always ready.
        popBase = popCount;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 1'b1, i, 2 * i, 1'b1);
            checkOutput("b2bReady", {63'd0, s_ready}, 64'd1);
        end
        repeat (6) applyStimulus(1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
        checkOutput("b2bPopCount", 64'(popCount - popBase), 64'd16);
        checkOutput("b2bDrained", 64'(sbQ.size()), 64'd0);

        // Backpressure: four accepts, head held stable, ready returns after first pop.
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1, 1'b1, 100 + k, k, 1'b0);
            checkOutput("bpReady", {63'd0, s_ready}, {63'd0, (k < 4)});
            if (k >= 3) begin
                checkOutput("bpHeadValid", {63'd0, m_valid}, 64'd1);
                checkOutput("bpHeadStable", {31'd0, m_sum}, 64'd100);
            end
        end
        applyStimulus(1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
        checkOutput("bpFirstPopReady", {63'd0, s_ready}, 64'd0);
        checkOutput("bpFirstPopSum", {31'd0, m_sum}, 64'd100);
        applyStimulus(1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
        checkOutput("bpReadyReturns", {63'd0, s_ready}, 64'd1);
        checkOutput("bpSecondSum", {31'd0, m_sum}, 64'd102);
        repeat (6) applyStimulus(1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
        checkOutput("bpDrained", 64'(sbQ.size()), 64'd0);

        // Full with a pop and a new request in the same cycle: no accept until next cycle.
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b1, 1'b1, 300 + k, 32'd0, 1'b0);
        end
        applyStimulus(1'b1, 1'b1, 32'd400, 32'd0, 1'b1);
        checkOutput("fullPopNoAccept", {63'd0, s_ready}, 64'd0);
        checkOutput("fullPopValid", {63'd0, m_valid}, 64'd1);
        applyStimulus(1'b1, 1'b1, 32'd401, 32'd0, 1'b1);
        checkOutput("fullPopNextAccept", {63'd0, s_ready}, 64'd1);
        repeat (8) applyStimulus(1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
        checkOutput("fullPopDrained", 64'(sbQ.size()), 64'd0);

        // Reset with two buffered and two still in the adder pipe.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 1'b1, 500 + k, k, 1'b0);
        end
        checkOutput("preResetBuffered", {63'd0, m_valid}, 64'd1);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        sbQ.delete();
        checkOutput("midRstMValid", {63'd0, m_valid}, 64'd0);
        checkOutput("midRstBusy", {63'd0, busy}, 64'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
            checkOutput("postRstNoStale", {63'd0, m_valid}, 64'd0);
        end
        checkOutput("postRstBusy", {63'd0, busy}, 64'd0);
        applyStimulus(1'b1, 1'b1, 32'd5, 32'd7, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
        checkOutput("postRstValid", {63'd0, m_valid}, 64'd1);
        checkOutput("postRstSum", {31'd0, m_sum}, 64'd12);
        applyStimulus(1'b1, 1'b0, 32'd0, 32'd0, 1'b1);

        // Random handshakes on both sides, bounded by a cycle budget.
        target = acceptCount + 1000;
        cycles = 0;
        while (acceptCount < target && cycles < 20000) begin
            applyStimulus(1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)));
            cycles++;
        end
        checkOutput("randAccepted", {63'd0, (acceptCount >= target)}, 64'd1);
        repeat (12) applyStimulus(1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
        checkOutput("randDrained", 64'(sbQ.size()), 64'd0);
        checkOutput("randIdleBusy", {63'd0, busy}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/add_stream_ctrl.md
# add_stream_ctrl

Streaming front/back-end for the registered 32-bit fast adder. It accepts operand pairs over a valid/ready handshake and drives the adder's `in_a`/`in_b`. It tracks the adder's fixed, non-stallable latency with a valid pipe, then captures the 33-bit `out_sum` into a result FIFO presented over a valid/ready handshake. Credit counting guarantees that no adder result is ever dropped under downstream backpressure.

## Interface
- `WIDTH`, 32: operand width; sum width is WIDTH+1.
- `LATENCY`, 2: adder cycles from operand presentation to valid `out_sum`.
- `RES_DEPTH`, 4: result FIFO depth; must be ≥ LATENCY+2 for full throughput; legal minimum 1.

- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low reset. The adder's own reset is active-high; the integration ties it to `~reset`.
- `s_valid`  in  1  operand pair valid.
- `s_ready`  out  1  controller can accept a pair.
- `s_a`, `s_b`  in  WIDTH  operands.
- `add_a`, `add_b`  out  WIDTH  to adder `in_a`/`in_b`.
- `add_sum`  in  WIDTH+1  from adder `out_sum`.
- `m_valid`  out  1  result available.
- `m_ready`  in  1  consumer accepts result.
- `m_sum`  out  WIDTH+1  result, zero-extended carry in MSB.
- `busy`  out  1  any result in flight or buffered.

## Operation
- fire = `s_valid && s_ready`. `add_a`/`add_b` = fire ? `s_a`/`s_b` : 0 (combinational, no register; the adder registers internally).
- Valid pipe: LATENCY-bit shift register. Bit 0 loads fire each cycle. The MSB (`cap`) marks that `add_sum` holds a real result this cycle.
- cap pushes `add_sum` into the result FIFO. The FIFO never overflows; guaranteed by credits.
- pop = `m_valid && m_ready`. `m_valid` = FIFO not empty. `m_sum` = FIFO head, held stable while `m_valid && !m_ready`.
- Occupancy counter, width clog2(RES_DEPTH+1):
  - +1 on fire, −1 on pop, unchanged on both.
  - It counts items in the valid pipe plus items in the FIFO.
- `s_ready` = occupancy < RES_DEPTH. Registered-state only, with no combinational path from `m_ready`. At occupancy == RES_DEPTH with a same-cycle pop, `s_ready` stays 0 that cycle.
- `busy` = occupancy != 0.
- Simultaneous push and pop on the FIFO: both happen and the count is unchanged. Pop from a 1-entry FIFO with simultaneous push: the new entry becomes head next cycle.
- Order preserved: results emerge in operand acceptance order.

## Timing
- Reset (reset==0 at an edge) clears:
  - the valid pipe, occupancy, and FIFO pointers/count;
  - `m_sum` register contents to 0.
- While `reset` is low: `s_ready`=0, `m_valid`=0, `busy`=0, `add_a`/`add_b`=0.
- First cycle after release: `s_ready`=1.
- Reset mid-operation discards all in-flight and buffered results. Adder outputs that arrive after release are ignored because the valid pipe is clear.
- Latency: fire in cycle t gives `add_sum` valid in cycle t+LATENCY, captured at end of t+LATENCY, and `m_valid`=1 in cycle t+LATENCY+1 (t+3 at defaults).
- Throughput: 1 pair/cycle sustained when `m_ready` is held high and RES_DEPTH ≥ LATENCY+2.
- Backpressure: with `m_ready`=0, exactly RES_DEPTH pairs are accepted, then `s_ready`=0 until a pop.

## Structure
- Package `add_stream_pkg`:
  - `WIDTH`/`LATENCY` defaults and `SUM_W` = WIDTH+1;
  - occupancy-width function clog2.
- Sub-module `sync_fifo` (WIDTH+1 data, RES_DEPTH entries, push/pop/full/empty/count, same reset). Reused for the result buffer.
- The controller holds the valid pipe, the occupancy counter, and port muxing.

## Test plan
- Reset then single pair a=0xFFFF_FFFF, b=1, `m_ready`=1 → `m_valid` exactly 3 cycles after fire, `m_sum`=0x1_0000_0000, `busy` falls the next cycle.
- 16 back-to-back pairs (a=i, b=2i) with `m_ready`=1 → `s_ready` never drops, 16 consecutive results 3i in order.
- `m_ready`=0 with continuous `s_valid` → exactly 4 accepts, then `s_ready`=0. `m_sum` holds the first result stably. Raising `m_ready` drains 4 results in order, and `s_ready` returns the cycle after the first pop.
- Occupancy 4 with pop and `s_valid` in the same cycle → no accept that cycle, accept next cycle, no loss or duplication.
- Reset asserted with 2 in flight and 2 buffered → after release `m_valid`=0 and no stale result ever appears. A new pair 5+7 returns 12.
- Random `s_valid`/`m_ready` (50%), 1000 pairs vs scoreboard → all sums are correct, in order, and the FIFO never overflows.
